bmc_decoder: RTL



---
 rtl/bmc_decoder_if.sv | 22 ++
 rtl/bmc_decoder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bmc_decoder_if.sv
// Decoded-word handshake between bmc_decoder and the downstream word RAM stage.
// The decoder presents a timestamped word; the consumer pulses the release line.
interface bmc_decoder_if;
    logic [16:0] decoded_data;
    logic [23:0] ts_decoded_data;
    logic        decoded_data_avl;
    logic        reset_bmc_decoder;

    modport master (
        output decoded_data,
        output ts_decoded_data,
        output decoded_data_avl,
        input  reset_bmc_decoder
    );

    modport slave (
        input  decoded_data,
        input  ts_decoded_data,
        input  decoded_data_avl,
        output reset_bmc_decoder
    );
endinterface

// File: rtl/bmc_decoder.sv
// Biphase-mark decoder for the TS4231 data line: recovers 17-bit words and timestamps them.
// Define BMC_GLITCH_FILTER_EN to add a 3-sample majority filter on the synchronized data pin.
module bmc_decoder #(
    parameter int HALF_MIN = 5,
    parameter int HALF_MAX = 11,
    parameter int FULL_MAX = 20
) (
    input  logic          clk_96MHz,
    input  logic          rst_n,
    input  logic          d_in,
    input  logic          e_in,
    bmc_decoder_if.master word_if
);
    // state  | meaning
    // IDLE   | waiting for a line edge while the envelope is active
    // SYNC   | following half bits, waiting for a full bit to lock on
    // DECODE | shifting in the 17 data bits
    // HOLD   | word presented, line ignored until released
    typedef enum logic [1:0] {IDLE, SYNC, DECODE, HOLD} state_t;

    localparam int CW = $clog2(FULL_MAX + 2);
    localparam logic [CW-1:0] HALF_MIN_C = CW'(HALF_MIN);
    localparam logic [CW-1:0] HALF_MAX_C = CW'(HALF_MAX);
    localparam logic [CW-1:0] FULL_MAX_C = CW'(FULL_MAX);
    localparam logic [CW-1:0] TMO_C      = CW'(FULL_MAX + 1);

    state_t        state, state_nxt;
    logic          d_s1, d_s2, e_s1, e_s2;
    logic          d_cur, d_prev, d_edge;
    logic [CW-1:0] int_cnt;
    logic [23:0]   ts_cnt, ts_reg;
    logic [15:0]   shift_reg;
    logic [16:0]   shift_nxt;
    logic [4:0]    bit_cnt;
    logic          half_pend;
    logic          env_ok, is_short, is_long, is_bad;
    logic          do_lock, do_half, do_shift, shift_bit, do_clear, word_done;

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            d_s1 <= 1'b0;
            d_s2 <= 1'b0;
            e_s1 <= 1'b0;
            e_s2 <= 1'b0;
        end else begin
            d_s1 <= d_in;
            d_s2 <= d_s1;
            e_s1 <= e_in;
            e_s2 <= e_s1;
        end
    end

`ifdef BMC_GLITCH_FILTER_EN
    logic d_m1, d_m2;

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            d_m1 <= 1'b0;
            d_m2 <= 1'b0;
        end else begin
            d_m1 <= d_s2;
            d_m2 <= d_m1;
        end
    end

    assign d_cur = (d_s2 & d_m1) | (d_s2 & d_m2) | (d_m1 & d_m2);
`else
    assign d_cur = d_s2;
`endif

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) d_prev <= 1'b0;
        else        d_prev <= d_cur;
    end

    assign d_edge = d_cur ^ d_prev;
    assign env_ok = ~e_s2;

    // Restarting at 1 makes the value seen at the next edge equal the edge spacing in clocks.
    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n)                int_cnt <= '0;
        else if (d_edge)           int_cnt <= CW'(1);
        else if (int_cnt != TMO_C) int_cnt <= int_cnt + CW'(1);
    end

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 24'd1;
    end

    assign is_short = d_edge && (int_cnt >= HALF_MIN_C) && (int_cnt <= HALF_MAX_C);
    assign is_long  = d_edge && (int_cnt >  HALF_MAX_C) && (int_cnt <= FULL_MAX_C);
    assign is_bad   = (d_edge && !is_short && !is_long) || (int_cnt == TMO_C);

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_lock   = 1'b0;
        do_half   = 1'b0;
        do_shift  = 1'b0;
        shift_bit = 1'b0;
        do_clear  = 1'b0;
        word_done = 1'b0;
        if (word_if.reset_bmc_decoder) begin
            state_nxt = IDLE;
            do_clear  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (env_ok && d_edge) state_nxt = SYNC;
                end
                SYNC: begin
                    if (!env_ok || is_bad) begin
                        state_nxt = IDLE;
                    end else if (is_long) begin
                        state_nxt = DECODE;
                        do_lock   = 1'b1;
                    end
                end
                DECODE: begin
                    if (!env_ok || is_bad || (is_long && half_pend)) begin
                        state_nxt = IDLE;
                    end else if (is_short) begin
                        if (half_pend) begin
                            do_shift  = 1'b1;
                            shift_bit = 1'b1;
                        end else begin
                            do_half = 1'b1;
                        end
                    end else if (is_long) begin
                        do_shift = 1'b1;
                    end
                    if (do_shift && (bit_cnt == 5'd16)) begin
                        word_done = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD: state_nxt = HOLD;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign shift_nxt = {shift_reg, shift_bit};

    always_ff @(posedge clk_96MHz or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg                <= '0;
            bit_cnt                  <= '0;
            half_pend                <= 1'b0;
            ts_reg                   <= '0;
            word_if.decoded_data     <= '0;
            word_if.ts_decoded_data  <= '0;
            word_if.decoded_data_avl <= 1'b0;
        end else if (do_clear) begin
            shift_reg                <= '0;
            bit_cnt                  <= '0;
            half_pend                <= 1'b0;
            word_if.decoded_data_avl <= 1'b0;
        end else begin
            if (do_lock) begin
                ts_reg    <= ts_cnt;
                bit_cnt   <= '0;
                half_pend <= 1'b0;
            end
            if (do_half) half_pend <= 1'b1;
            if (do_shift) begin
                shift_reg <= shift_nxt[15:0];
                bit_cnt   <= bit_cnt + 5'd1;
                half_pend <= 1'b0;
            end
            if (word_done) begin
                word_if.decoded_data     <= shift_nxt;
                word_if.ts_decoded_data  <= ts_reg;
                word_if.decoded_data_avl <= 1'b1;
            end
        end
    end
endmodule
